// File: rtl/fp32_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : fp32_multiplier
// Purpose  : Multi-cycle IEEE-754 binary32 multiplier (RNE) with start/done
//            handshake and NaN/infinity/overflow/underflow flags.
// Options  : define FP32_MUL_FTZ_EN to flush subnormal inputs/results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        start_i,
  output logic        done_o,
  output logic        nan_o,
  output logic        inifinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic [31:0] product_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_MULT   = 3'd2;
  localparam logic [2:0] ST_NORM   = 3'd3;
  localparam logic [2:0] ST_ROUND  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] K_NUM  = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_INF  = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [2:0]         state_q, state_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic               sign_q, sign_d;
  logic [1:0]         kind_q, kind_d;
  logic signed [9:0]  ea_q, ea_d;
  logic signed [9:0]  eb_q, eb_d;
  logic [23:0]        ma_q, ma_d;
  logic [23:0]        mb_q, mb_d;
  logic [47:0]        prod_q, prod_d;
  logic signed [10:0] exp_q, exp_d;
  logic signed [10:0] exn_q, exn_d;
  logic [23:0]        mant_q, mant_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               tiny_q, tiny_d;
  logic [31:0]        product_q, product_d;
  logic               nan_q, nan_d;
  logic               inf_q, inf_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [1:0]         ka, kb;
  logic [47:0]        norm_pn;
  logic signed [10:0] norm_e;
`ifndef FP32_MUL_FTZ_EN
  logic [10:0]        norm_sh;
  logic [73:0]        norm_wide;
`endif
  logic               rnd_inc;
  logic [24:0]        rnd_mant;
  logic signed [10:0] rnd_exp;

  function automatic logic [1:0] classify(input logic [30:0] x);
    if (x[30:23] == 8'hFF) begin
      return (x[22:0] != 23'd0) ? K_NAN : K_INF;
    end
`ifdef FP32_MUL_FTZ_EN
    if (x[30:23] == 8'h00) return K_ZERO;
`else
    if (x[30:0] == 31'd0) return K_ZERO;
`endif
    return K_NUM;
  endfunction

  // Returns {biased exponent (signed, 10b), mantissa with bit 23 set}.
  // Subnormals are normalised so the exponent may go below 1.
  function automatic logic [33:0] unpack_op(input logic [30:0] x);
    logic [9:0]  e;
    logic [23:0] m;
`ifdef FP32_MUL_FTZ_EN
    e = {2'b00, x[30:23]};
    m = {1'b1, x[22:0]};
`else
    logic [4:0] lz;
    if (x[30:23] != 8'h00) begin
      e = {2'b00, x[30:23]};
      m = {1'b1, x[22:0]};
    end else begin
      lz = 5'd0;
      for (int i = 0; i < 23; i++) begin
        if (x[i]) lz = 5'(23 - i);
      end
      m = {1'b0, x[22:0]} << lz;
      e = 10'd1 - {5'd0, lz};
    end
`endif
    return {e, m};
  endfunction

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    kind_d    = kind_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    prod_d    = prod_q;
    exp_d     = exp_q;
    exn_d     = exn_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    tiny_d    = tiny_q;
    product_d = product_q;
    nan_d     = nan_q;
    inf_d     = inf_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ka        = K_NUM;
    kb        = K_NUM;
    norm_pn   = 48'd0;
    norm_e    = 11'sd0;
`ifndef FP32_MUL_FTZ_EN
    norm_sh   = 11'd0;
    norm_wide = 74'd0;
`endif
    rnd_inc   = 1'b0;
    rnd_mant  = 25'd0;
    rnd_exp   = 11'sd0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          opa_d   = a_i;
          opb_d   = b_i;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        ka     = classify(opa_q[30:0]);
        kb     = classify(opb_q[30:0]);
        sign_d = opa_q[31] ^ opb_q[31];
        if (ka == K_NAN || kb == K_NAN ||
            (ka == K_ZERO && kb == K_INF) || (ka == K_INF && kb == K_ZERO))
          kind_d = K_NAN;
        else if (ka == K_INF || kb == K_INF)
          kind_d = K_INF;
        else if (ka == K_ZERO || kb == K_ZERO)
          kind_d = K_ZERO;
        else
          kind_d = K_NUM;
        {ea_d, ma_d} = unpack_op(opa_q[30:0]);
        {eb_d, mb_d} = unpack_op(opb_q[30:0]);
        state_d = ST_MULT;
      end

      ST_MULT: begin
        prod_d  = {24'd0, ma_q} * {24'd0, mb_q};
        exp_d   = {ea_q[9], ea_q} + {eb_q[9], eb_q} - 11'sd127;
        state_d = ST_NORM;
      end

      ST_NORM: begin
        // Product lies in [2^46, 2^48); align so the leading one is bit 47.
        norm_pn = prod_q[47] ? prod_q : {prod_q[46:0], 1'b0};
        norm_e  = exp_q + {10'd0, prod_q[47]};
        exn_d   = norm_e;
        tiny_d  = (norm_e < 11'sd1);
        if (norm_e >= 11'sd1) begin
          mant_d   = norm_pn[47:24];
          guard_d  = norm_pn[23];
          sticky_d = |norm_pn[22:0];
        end else begin
`ifdef FP32_MUL_FTZ_EN
          mant_d   = 24'd0;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
`else
          norm_sh = 11'd1 - norm_e;
          if (norm_sh > 11'd25) begin
            mant_d   = 24'd0;
            guard_d  = 1'b0;
            sticky_d = 1'b1;
          end else begin
            norm_wide = {norm_pn, 26'd0} >> norm_sh[4:0];
            mant_d    = norm_wide[73:50];
            guard_d   = norm_wide[49];
            sticky_d  = |norm_wide[48:0];
          end
`endif
        end
        state_d = ST_ROUND;
      end

      ST_ROUND: begin
        rnd_inc  = guard_q & (sticky_q | mant_q[0]);
        rnd_mant = {1'b0, mant_q} + {24'd0, rnd_inc};
        // A subnormal carrying into bit 23 becomes the smallest normal.
        rnd_exp  = tiny_q ? {10'd0, rnd_mant[23]} : exn_q + {10'd0, rnd_mant[24]};
        nan_d    = 1'b0;
        inf_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        case (kind_q)
          K_NAN: begin
            product_d = QNAN;
            nan_d     = 1'b1;
          end
          K_INF: begin
            product_d = {sign_q, 8'hFF, 23'd0};
            inf_d     = 1'b1;
          end
          K_ZERO: begin
            product_d = {sign_q, 31'd0};
          end
          default: begin
            if (!tiny_q && rnd_exp >= 11'sd255) begin
              product_d = {sign_q, 8'hFF, 23'd0};
              ovf_d     = 1'b1;
              inf_d     = 1'b1;
            end
`ifdef FP32_MUL_FTZ_EN
            else if (tiny_q) begin
              product_d = {sign_q, 31'd0};
              unf_d     = 1'b1;
            end
`endif
            else begin
              product_d = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
              unf_d     = tiny_q & (guard_q | sticky_q);
            end
          end
        endcase
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      sign_q    <= 1'b0;
      kind_q    <= K_NUM;
      ea_q      <= 10'sd0;
      eb_q      <= 10'sd0;
      ma_q      <= 24'd0;
      mb_q      <= 24'd0;
      prod_q    <= 48'd0;
      exp_q     <= 11'sd0;
      exn_q     <= 11'sd0;
      mant_q    <= 24'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      tiny_q    <= 1'b0;
      product_q <= 32'd0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sign_q    <= sign_d;
      kind_q    <= kind_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      prod_q    <= prod_d;
      exp_q     <= exp_d;
      exn_q     <= exn_d;
      mant_q    <= mant_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      tiny_q    <= tiny_d;
      product_q <= product_d;
      nan_q     <= nan_d;
      inf_q     <= inf_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign done_o      = (state_q == ST_DONE);
  assign product_o   = product_q;
  assign nan_o       = nan_q;
  assign inifinit_o  = inf_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_multiplier
// Purpose  : Directed and random checks of fp32_multiplier against a
//            double-precision reference rounded to binary32 (RNE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_multiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        start_i;
  logic        done_o;
  logic        nan_o;
  logic        inifinit_o;
  logic        overflow_o;
  logic        underflow_o;
  logic [31:0] product_o;

  int   n_checks;
  int   n_fail;
  int   done_rises;
  logic done_prev;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  f;   // {nan, inf, overflow, underflow}
  } vec_t;

  vec_t vecs [15];

  fp32_multiplier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a_i),
    .b_i         (b_i),
    .start_i     (start_i),
    .done_o      (done_o),
    .nan_o       (nan_o),
    .inifinit_o  (inifinit_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .product_o   (product_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (done_o && !done_prev) done_rises++;
    done_prev = done_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // binary32 -> binary64 bit pattern (exact, subnormals normalised)
  function automatic logic [63:0] f2d(input logic [31:0] x);
    logic [63:0] fx;
    int          p;
    if (x[30:23] == 8'hFF)
      return (x[22:0] != 0) ? 64'h7FF8_0000_0000_0000 : {x[31], 11'h7FF, 52'd0};
    if (x[30:23] == 8'h00) begin
      if (x[22:0] == 0) return {x[31], 63'd0};
      p = 0;
      for (int i = 0; i < 23; i++) if (x[i]) p = i;
      fx = {41'd0, x[22:0]} << (52 - p);
      return {x[31], 11'(p + 874), fx[51:0]};
    end
    return {x[31], 11'({3'd0, x[30:23]} + 11'd896), x[22:0], 29'd0};
  endfunction

  // binary64 -> binary32 with round-to-nearest-even and gradual underflow
  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic        s;
    logic [10:0] e;
    logic [63:0] m, kept, rem, half;
    int          ue, sh;
    s = d[63];
    e = d[62:52];
    if (e == 11'h7FF) return (d[51:0] != 0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    if (e == 11'h000) return {s, 31'd0};
    m  = {11'd0, 1'b1, d[51:0]};
    ue = int'(e) - 1023;
    sh = (ue >= -126) ? 29 : 29 + (-126 - ue);
    if (sh >= 64) return {s, 31'd0};
    kept = m >> sh;
    rem  = m & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    if (ue >= -126) begin
      if (kept == (64'd1 << 24)) begin
        kept = kept >> 1;
        ue   = ue + 1;
      end
      if (ue + 127 >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(ue + 127), kept[22:0]};
    end
    return {s, 31'(kept)};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = $bitstoreal(f2d(a));
    rb = $bitstoreal(f2d(b));
    return d2f($realtobits(ra * rb));
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic hold,
                       input logic [31:0] exp_p, input logic [3:0] exp_f,
                       input logic chk_f, input string tag);
    int lat;
    @(negedge clk);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start_i = 1'b0;
      a_i     = ~a;
      b_i     = ~b;
    end
    lat = 1;
    while (!done_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, lat, 5);
    check_eq({tag, " product"}, product_o, exp_p);
    if (chk_f)
      check_eq({tag, " flags"}, {28'd0, nan_o, inifinit_o, overflow_o, underflow_o},
               {28'd0, exp_f});
    @(posedge clk);
    #1;
    if (chk_f) check_eq({tag, " done width"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          rises0;

    n_checks  = 0;
    n_fail    = 0;
    done_rises = 0;
    done_prev = 1'b0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    a_i       = 32'd0;
    b_i       = 32'd0;

    vecs[0]  = {32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = {32'hC0400000, 32'h3F000000, 32'hBFC00000, 4'b0000};
    vecs[2]  = {32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000};
    vecs[3]  = {32'h3F800001, 32'h3F800000, 32'h3F800001, 4'b0000};
    vecs[4]  = {32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0110};
    vecs[5]  = {32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[6]  = {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = {32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000};
    vecs[8]  = {32'h00000001, 32'h3F000000, 32'h00000000, 4'b0001};
    vecs[9]  = {32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0100};
    vecs[10] = {32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000};
    vecs[11] = {32'h007FFFFF, 32'h3F800001, 32'h00800000, 4'b0001};
    vecs[12] = {32'h3F800000, 32'hFFC00000, 32'h7FC00000, 4'b1000};
    vecs[13] = {32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[14] = {32'h40400000, 32'h40400000, 32'h41100000, 4'b0000};

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset product", product_o, 32'd0);
    check_eq("reset flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'd0);
    check_eq("reset done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].p, vecs[i].f, 1'b1, $sformatf("vec%0d", i));

    // Back-to-back with start held high
    rises0 = done_rises;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      do_op(ra, rb, 1'b1, ref_mul(ra, rb), 4'b0000, 1'b0, $sformatf("rnd%0d", i));
    end
    start_i = 1'b0;
    check_eq("rnd done rises", done_rises - rises0, 100);

    // Reset pulse while the FSM is in MULT
    do_op(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1, "pre-reset");
    @(negedge clk);
    a_i     = 32'h7F7FFFFF;
    b_i     = 32'h40000000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort product", product_o, 32'd0);
    check_eq("abort flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'd0);
    check_eq("abort done", {31'd0, done_o}, 32'd0);
    rises0 = done_rises;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort no done", done_rises - rises0, 0);
    do_op(32'hC0400000, 32'h3F000000, 1'b0, 32'hBFC00000, 4'b0000, 1'b1, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
